// File: rtl/fsign_pipe.sv
// ---------------------------------------------------------------------------
// fsign_pipe
//   FPU sign-injection unit covering FSGNJ/FSGNJN/FSGNJX/FABS/FNEG/FMV.
//   The result is formed combinationally and written into stage 0 of an
//   elastic, STAGES-deep valid/ready pipeline. A sideband tag (the
//   destination register) travels with each result, and results leave in
//   issue order.
//
//   Optional feature macro: FSIGN_CANON_NAN_EN
//     defined   : a NaN x1 makes every legal op return the canonical quiet
//                 NaN (+, exponent all ones, mantissa MSB set).
//     undefined : NaN payload and sign are treated as plain bits.
//
// Ports
//   clk        in   clock, rising edge
//   rstn       in   synchronous active-low reset
//   in_valid   in   operation offered
//   in_ready   out  unit can accept this cycle (combinational on out_ready)
//   op         in   000 SGNJ, 001 SGNJN, 010 SGNJX, 011 ABS, 100 NEG,
//                   101 MV, 11x illegal
//   x1         in   magnitude/source operand
//   x2         in   sign-source operand
//   tag_in     in   sideband tag, returned unchanged
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   y          out  result
//   tag_out    out  tag of the result
//   illegal    out  result came from an illegal op
//   busy       out  any stage holds a valid entry
// ---------------------------------------------------------------------------
module fsign_pipe #(
  parameter int WIDTH  = 32,
  parameter int EXP_W  = 8,
  parameter int STAGES = 1,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [TAG_W-1:0] tag_out,
  output logic             illegal,
  output logic             busy
);

  localparam logic [2:0] OP_SGNJ  = 3'b000;
  localparam logic [2:0] OP_SGNJN = 3'b001;
  localparam logic [2:0] OP_SGNJX = 3'b010;
  localparam logic [2:0] OP_ABS   = 3'b011;
  localparam logic [2:0] OP_NEG   = 3'b100;
  localparam logic [2:0] OP_MV    = 3'b101;

`ifdef FSIGN_CANON_NAN_EN
  localparam bit CANON_NAN = 1'b1;
`else
  localparam bit CANON_NAN = 1'b0;
`endif

  localparam int MAN_W = WIDTH - 1 - EXP_W;

  // NaN test on the unsigned part of an operand: exponent all ones, mantissa non-zero.
  function automatic logic is_nan(input logic [WIDTH-2:0] mag);
    return (&mag[WIDTH-2 -: EXP_W]) && (|mag[MAN_W-1:0]);
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
  function automatic logic [WIDTH-1:0] canon_nan();
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    r[WIDTH-2 -: EXP_W] = {EXP_W{1'b1}};
    r[MAN_W-1] = 1'b1;
    return r;
  endfunction

  logic [WIDTH-1:0] base_y_s;
  logic [WIDTH-1:0] res_y_s;
  logic             res_ill_s;
  logic [STAGES-1:0] ld_s;

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] il_q, il_d;
  logic [WIDTH-1:0]  y_q [STAGES];
  logic [WIDTH-1:0]  y_d [STAGES];
  logic [TAG_W-1:0]  t_q [STAGES];
  logic [TAG_W-1:0]  t_d [STAGES];

  // Sign-injection result for the operation currently offered.
  always_comb begin
    base_y_s  = x1;
    res_ill_s = 1'b0;
    case (op)
      OP_SGNJ:  base_y_s = {x2[WIDTH-1], x1[WIDTH-2:0]};
      OP_SGNJN: base_y_s = {~x2[WIDTH-1], x1[WIDTH-2:0]};
      OP_SGNJX: base_y_s = {x1[WIDTH-1] ^ x2[WIDTH-1], x1[WIDTH-2:0]};
      OP_ABS:   base_y_s = {1'b0, x1[WIDTH-2:0]};
      OP_NEG:   base_y_s = {~x1[WIDTH-1], x1[WIDTH-2:0]};
      OP_MV:    base_y_s = x1;
      default: begin
        base_y_s  = x1;
        res_ill_s = 1'b1;
      end
    endcase
    // Illegal ops pass x1 through untouched, so canonicalisation skips them.
    res_y_s = (CANON_NAN && !res_ill_s && is_nan(x1[WIDTH-2:0])) ? canon_nan() : base_y_s;
  end

  // Load enables, walked back from the consumer: a stage may load when it is
  // empty or its current entry moves on this cycle.
  always_comb begin
    logic nxt;
    nxt  = out_ready;
    ld_s = {STAGES{1'b0}};
    for (int k = STAGES - 1; k >= 0; k--) begin
      nxt     = ~v_q[k] | nxt;
      ld_s[k] = nxt;
    end
  end

  // Next state of every stage: shift forward where enabled, otherwise hold.
  always_comb begin
    v_d  = v_q;
    il_d = il_q;
    y_d  = y_q;
    t_d  = t_q;
    if (ld_s[0]) begin
      v_d[0]  = in_valid;
      il_d[0] = res_ill_s;
      y_d[0]  = res_y_s;
      t_d[0]  = tag_in;
    end else begin
      v_d[0] = v_q[0];
    end
    for (int k = 1; k < STAGES; k++) begin
      if (ld_s[k]) begin
        v_d[k]  = v_q[k-1];
        il_d[k] = il_q[k-1];
        y_d[k]  = y_q[k-1];
        t_d[k]  = t_q[k-1];
      end else begin
        v_d[k] = v_q[k];
      end
    end
  end

  // Stage registers; reset empties the pipe and clears the visible outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v_q  <= {STAGES{1'b0}};
      il_q <= {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
        y_q[k] <= {WIDTH{1'b0}};
        t_q[k] <= {TAG_W{1'b0}};
      end
    end else begin
      v_q  <= v_d;
      il_q <= il_d;
      y_q  <= y_d;
      t_q  <= t_d;
    end
  end

  assign in_ready  = ld_s[0];
  assign out_valid = v_q[STAGES-1];
  assign y         = y_q[STAGES-1];
  assign tag_out   = t_q[STAGES-1];
  assign illegal   = il_q[STAGES-1];
  assign busy      = |v_q;

endmodule

// File: tb/tb_fsign_pipe.sv
module tb_fsign_pipe;
  localparam int W  = 32;
  localparam int ST = 3;
  localparam int TW = 5;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  x1;
  logic [W-1:0]  x2;
  logic [TW-1:0] tag_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic [TW-1:0] tag_out;
  logic          illegal;
  logic          busy;

  fsign_pipe #(.WIDTH(W), .EXP_W(8), .STAGES(ST), .TAG_W(TW)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x1(x1), .x2(x2), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .tag_out(tag_out),
    .illegal(illegal), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // observations taken at the falling edge
  logic          acc, emit, obs_ov, obs_ir;
  logic [W-1:0]  obs_y;
  logic [TW-1:0] obs_t;
  logic          obs_i;

  // scoreboard of accepted ops
  logic [W-1:0]  eq_y[$];
  logic [TW-1:0] eq_t[$];
  logic          eq_i[$];

  localparam logic [2:0]  D_OP [8] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd7};
  localparam logic [31:0] D_X1 [8] = '{32'h3F800000, 32'hBF800000, 32'hC0490FDB, 32'hC0490FDB,
                                       32'hC0490FDB, 32'hC0490FDB, 32'h3F800000, 32'h12345678};
  localparam logic [31:0] D_X2 [8] = '{32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000,
                                       32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
  localparam logic [31:0] D_Y  [8] = '{32'hBF800000, 32'h3F800000, 32'h40490FDB, 32'h40490FDB,
                                       32'hC0490FDB, 32'hC0490FDB, 32'h3F800000, 32'h12345678};
  localparam logic        D_IL [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Reference: sign of result chosen from the op's rule, magnitude always x1's.
  function automatic logic [31:0] ref_y(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic sa, sb;
    logic [30:0] mag;
    sa  = a[31];
    sb  = b[31];
    mag = a[30:0];
    if (o >= 3'd6) return a;
`ifdef FSIGN_CANON_NAN_EN
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return 32'h7FC00000;
`endif
    case (o)
      3'd0:    return {sb, mag};
      3'd1:    return {~sb, mag};
      3'd2:    return {sa ^ sb, mag};
      3'd3:    return {1'b0, mag};
      3'd4:    return {~sa, mag};
      default: return a;
    endcase
  endfunction

  // One clock: observe handshakes at negedge, record accepted ops, step past posedge.
  task automatic tick();
    @(negedge clk);
    acc    = in_valid & in_ready;
    emit   = out_valid & out_ready;
    obs_ov = out_valid;
    obs_ir = in_ready;
    obs_y  = y;
    obs_t  = tag_out;
    obs_i  = illegal;
    if (acc && rstn) begin
      eq_y.push_back(ref_y(op, x1, x2));
      eq_t.push_back(tag_in);
      eq_i.push_back(op >= 3'd6);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    eq_y.delete();
    eq_t.delete();
    eq_i.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; x1 = 32'd0; x2 = 32'd0; tag_in = 5'd0;
    repeat (3) tick();
    rstn = 1'b1;
    clear_sb();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (y !== 32'd0) begin n_bad++; $display("FAIL reset_y: got %h want 0", y); end
    n_cmp++; if (tag_out !== 5'd0) begin n_bad++; $display("FAIL reset_tag: got %h want 0", tag_out); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; op = D_OP[i]; x1 = D_X1[i]; x2 = D_X2[i]; tag_in = TW'(i + 1);
      tick();
      n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL dir_accept[%0d]: got %b want 1", i, acc); end
      in_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 10 && lat == 0; c++) begin
        tick();
        if (emit) lat = c;
      end
      n_cmp++; if (lat != ST) begin n_bad++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, ST); end
      n_cmp++; if (obs_y !== D_Y[i]) begin n_bad++; $display("FAIL dir_y[%0d]: got %h want %h", i, obs_y, D_Y[i]); end
      n_cmp++; if (obs_i !== D_IL[i]) begin n_bad++; $display("FAIL dir_illegal[%0d]: got %b want %b", i, obs_i, D_IL[i]); end
      n_cmp++; if (obs_t !== TW'(i + 1)) begin n_bad++; $display("FAIL dir_tag[%0d]: got %0d want %0d", i, obs_t, i + 1); end
    end
    clear_sb();
  endtask

  task automatic test_stall();
    logic [2:0]  s_op [5];
    logic [31:0] s_x1 [5];
    logic [31:0] s_x2 [5];
    int i, blk_at, ndone, stab_bad;
    logic [W-1:0] held_y;
    for (int k = 0; k < 5; k++) begin
      s_op[k] = 3'($urandom_range(0, 5)); s_x1[k] = $urandom; s_x2[k] = $urandom;
    end
    i = 0; blk_at = -1; stab_bad = 0; held_y = 32'd0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (i < 5);
      if (i < 5) begin op = s_op[i]; x1 = s_x1[i]; x2 = s_x2[i]; tag_in = TW'(i + 1); end
      tick();
      if (acc) i++;
      if (!obs_ir && blk_at < 0) begin blk_at = i; held_y = obs_y; end
      else if (!obs_ir && obs_y !== held_y) stab_bad++;
    end
    n_cmp++; if (i != 3) begin n_bad++; $display("FAIL stall_accepts: got %0d want 3", i); end
    n_cmp++; if (blk_at != 3) begin n_bad++; $display("FAIL stall_block_point: got %0d want 3", blk_at); end
    n_cmp++; if (stab_bad != 0) begin n_bad++; $display("FAIL stall_hold: %0d changes, want 0", stab_bad); end
    n_cmp++; if (obs_ov !== 1'b1 || obs_t !== 5'd1) begin n_bad++; $display("FAIL stall_head: valid %b tag %0d want 1/1", obs_ov, obs_t); end
    n_cmp++; if (eq_y.size() == 0 || obs_y !== eq_y[0]) begin n_bad++; $display("FAIL stall_head_y: got %h", obs_y); end
    out_ready = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40 && ndone < 5; c++) begin
      in_valid = (i < 5);
      if (i < 5) begin op = s_op[i]; x1 = s_x1[i]; x2 = s_x2[i]; tag_in = TW'(i + 1); end
      tick();
      if (acc) i++;
      if (emit) begin
        n_cmp++;
        if (eq_y.size() == 0 || obs_y !== eq_y[0] || obs_t !== TW'(ndone + 1) || obs_i !== eq_i[0]) begin
          n_bad++; $display("FAIL stall_drain[%0d]: got y=%h tag=%0d want tag %0d", ndone, obs_y, obs_t, ndone + 1);
        end
        if (eq_y.size() != 0) begin void'(eq_y.pop_front()); void'(eq_t.pop_front()); void'(eq_i.pop_front()); end
        ndone++;
      end
    end
    in_valid = 1'b0;
    repeat (4) tick();
    n_cmp++; if (ndone != 5 || emit !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL stall_count: got %0d results busy %b want 5/0", ndone, busy); end
    clear_sb();
  endtask

  // Streaming (rnd=0: continuous) or random in_valid/out_ready back-to-back traffic.
  task automatic run_traffic(input int n, input bit rnd, input string name);
    logic [2:0]  r_op [100];
    logic [31:0] r_x1 [100];
    logic [31:0] r_x2 [100];
    int i, ndone, first_acc, first_emit, gaps, stab_bad;
    logic prev_stall;
    logic [W-1:0] prev_y;
    logic [TW-1:0] prev_t;
    for (int k = 0; k < n; k++) begin
      r_op[k] = 3'($urandom_range(0, 7)); r_x1[k] = $urandom; r_x2[k] = $urandom;
      if ($urandom_range(0, 3) == 0) r_x1[k] = r_x1[k] | 32'h7F800000;
    end
    i = 0; ndone = 0; first_acc = -1; first_emit = -1; gaps = 0; stab_bad = 0;
    prev_stall = 1'b0; prev_y = 32'd0; prev_t = 5'd0;
    for (int c = 0; c < 1000 && ndone < n; c++) begin
      in_valid  = (i < n) && (!rnd || $urandom_range(0, 3) != 0);
      out_ready = !rnd || ($urandom_range(0, 2) != 0);
      op = r_op[i % n]; x1 = r_x1[i % n]; x2 = r_x2[i % n]; tag_in = TW'(i);
      tick();
      if (prev_stall && (obs_y !== prev_y || obs_t !== prev_t)) stab_bad++;
      prev_stall = obs_ov & ~out_ready;
      prev_y = obs_y; prev_t = obs_t;
      if (acc) begin if (i == 0) first_acc = c; i++; end
      if (!obs_ov && ndone > 0) gaps++;
      if (emit) begin
        if (ndone == 0) first_emit = c;
        n_cmp++;
        if (eq_y.size() == 0 || obs_y !== eq_y[0] || obs_t !== eq_t[0] || obs_i !== eq_i[0]) begin
          n_bad++; $display("FAIL %s[%0d]: got y=%h tag=%0d ill=%b", name, ndone, obs_y, obs_t, obs_i);
        end
        if (eq_y.size() != 0) begin void'(eq_y.pop_front()); void'(eq_t.pop_front()); void'(eq_i.pop_front()); end
        ndone++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (ndone != n) begin n_bad++; $display("FAIL %s_count: got %0d want %0d", name, ndone, n); end
    n_cmp++; if (stab_bad != 0) begin n_bad++; $display("FAIL %s_hold: %0d changes under stall, want 0", name, stab_bad); end
    if (!rnd) begin
      n_cmp++; if (first_emit - first_acc != ST) begin n_bad++; $display("FAIL %s_fill: got %0d want %0d", name, first_emit - first_acc, ST); end
      n_cmp++; if (gaps != 0) begin n_bad++; $display("FAIL %s_gaps: got %0d want 0", name, gaps); end
    end
    repeat (4) tick();
    clear_sb();
  endtask

  task automatic test_reset_flight();
    int i, nemit;
    out_ready = 1'b0; i = 0;
    for (int c = 0; c < 10 && i < 2; c++) begin
      in_valid = 1'b1; op = 3'd4; x1 = 32'h12340000 + 32'(i); x2 = 32'd0; tag_in = TW'(20 + i);
      tick();
      if (acc) i++;
    end
    in_valid = 1'b0;
    n_cmp++; if (i != 2 || busy !== 1'b1) begin n_bad++; $display("FAIL rflight_setup: accepted %0d busy %b want 2/1", i, busy); end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    clear_sb();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || y !== 32'd0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rflight_state: ov=%b busy=%b y=%h ir=%b want 0/0/0/1", out_valid, busy, y, in_ready);
    end
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd5; x1 = 32'hCAFE0000; tag_in = 5'd22;
    tick();
    in_valid = 1'b0; nemit = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (emit) begin
        nemit++;
        n_cmp++; if (obs_t !== 5'd22 || obs_y !== 32'hCAFE0000) begin n_bad++; $display("FAIL rflight_tag: got tag %0d y %h want 22/cafe0000", obs_t, obs_y); end
      end
    end
    n_cmp++; if (nemit != 1) begin n_bad++; $display("FAIL rflight_count: got %0d want 1", nemit); end
    clear_sb();
  endtask

  task automatic test_nan();
    logic [31:0] want;
    int got;
`ifdef FSIGN_CANON_NAN_EN
    want = 32'h7FC00000;
`else
    want = 32'h7FC12345;
`endif
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd4; x1 = 32'hFFC12345; x2 = 32'd0; tag_in = 5'd7;
    tick();
    in_valid = 1'b0; got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      tick();
      if (emit) got = 1;
    end
    n_cmp++; if (got != 1 || obs_y !== want) begin n_bad++; $display("FAIL nan_neg: got %h want %h", obs_y, want); end
    clear_sb();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    run_traffic(100, 1'b0, "stream");
    run_traffic(60, 1'b1, "back_to_back");
    test_reset_flight();
    test_nan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
